// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, ALUOp encodings, default widths
// and the packed control payload used by the ID/EX register.
package pipeline_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RAW_DEF  = 5;
    localparam int unsigned FUNCT_W  = 10;
    localparam int unsigned CNT_W    = 32;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_R     = 2'b00,
        ALU_I     = 2'b01,
        ALU_STORE = 2'b10
    } alu_op_e;

    // ALUOp is carried as raw bits so any decoder value passes through untouched
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoder-side inputs, EX-side registered outputs,
// stall/flush controls, hazard and bubble count.
interface id_ex_stage_if #(
    parameter int unsigned XLEN = pipeline_pkg::XLEN_DEF,
    parameter int unsigned RAW  = pipeline_pkg::RAW_DEF
) ();

    logic [1:0]      ALUOp_i;
    logic            ALUSrc_i;
    logic            RegWrite_i;
    logic            MemToReg_i;
    logic            MemRead_i;
    logic            MemWrite_i;
    logic [XLEN-1:0] RS1data_i;
    logic [XLEN-1:0] RS2data_i;
    logic [XLEN-1:0] Imm_i;
    logic [9:0]      funct_i;
    logic [RAW-1:0]  RS1addr_i;
    logic [RAW-1:0]  RS2addr_i;
    logic [RAW-1:0]  RDaddr_i;
    logic            stall_i;
    logic            flush_i;

    logic [1:0]      ALUOp_o;
    logic            ALUSrc_o;
    logic            RegWrite_o;
    logic            MemToReg_o;
    logic            MemRead_o;
    logic            MemWrite_o;
    logic [XLEN-1:0] RS1data_o;
    logic [XLEN-1:0] RS2data_o;
    logic [XLEN-1:0] Imm_o;
    logic [9:0]      funct_o;
    logic [RAW-1:0]  RS1addr_o;
    logic [RAW-1:0]  RS2addr_o;
    logic [RAW-1:0]  RDaddr_o;
    logic            hazard_o;
    logic [31:0]     bubble_cnt_o;

    modport master (
        output ALUOp_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i,
        output RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
        output stall_i, flush_i,
        input  ALUOp_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o,
        input  RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
        input  hazard_o, bubble_cnt_o
    );

    modport slave (
        input  ALUOp_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i,
        input  RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
        input  stall_i, flush_i,
        output ALUOp_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o,
        output RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
        output hazard_o, bubble_cnt_o
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detect: a load in EX whose destination (non-x0) matches
// either ID source register. Both sources are compared unconditionally.
module load_use_detect #(
    parameter int unsigned RAW = pipeline_pkg::RAW_DEF
) (
    input  logic           mem_read,
    input  logic [RAW-1:0] rd_addr,
    input  logic [RAW-1:0] rs1_addr,
    input  logic [RAW-1:0] rs2_addr,
    output logic           hazard_c
);

    assign hazard_c = mem_read && (rd_addr != '0) &&
                      ((rd_addr == rs1_addr) || (rd_addr == rs2_addr));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, stall hold and sticky flush.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned RAW  = RAW_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_stage_if.slave bus
);

    ctrl_t               ctrl_q;
    ctrl_t               ctrl_in;
    logic [XLEN-1:0]     rs1_data_q;
    logic [XLEN-1:0]     rs2_data_q;
    logic [XLEN-1:0]     imm_q;
    logic [FUNCT_W-1:0]  funct_q;
    logic [RAW-1:0]      rs1_addr_q;
    logic [RAW-1:0]      rs2_addr_q;
    logic [RAW-1:0]      rd_addr_q;
    logic                flush_pend_q;
    logic                hazard_c;
    logic                load_bubble_c;

    load_use_detect #(.RAW(RAW)) u_load_use_detect (
        .mem_read (ctrl_q.mem_read),
        .rd_addr  (rd_addr_q),
        .rs1_addr (bus.RS1addr_i),
        .rs2_addr (bus.RS2addr_i),
        .hazard_c (hazard_c)
    );

    assign ctrl_in = {bus.ALUOp_i, bus.ALUSrc_i, bus.RegWrite_i,
                      bus.MemToReg_i, bus.MemRead_i, bus.MemWrite_i};

    // Stall dominates; otherwise flush (live or remembered) or hazard forces a bubble
    assign load_bubble_c = !bus.stall_i && (bus.flush_i || flush_pend_q || hazard_c);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q       <= BUBBLE;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            funct_q      <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_addr_q    <= '0;
            flush_pend_q <= 1'b0;
        end else if (bus.stall_i) begin
            if (bus.flush_i) begin
                flush_pend_q <= 1'b1;
            end
        end else if (load_bubble_c) begin
            ctrl_q       <= BUBBLE;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            funct_q      <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_addr_q    <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_in;
            rs1_data_q   <= bus.RS1data_i;
            rs2_data_q   <= bus.RS2data_i;
            imm_q        <= bus.Imm_i;
            funct_q      <= bus.funct_i;
            rs1_addr_q   <= bus.RS1addr_i;
            rs2_addr_q   <= bus.RS2addr_i;
            rd_addr_q    <= bus.RDaddr_i;
            flush_pend_q <= 1'b0;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_q <= '0;
        end else if (load_bubble_c) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign bus.bubble_cnt_o = bubble_cnt_q;
`else
    assign bus.bubble_cnt_o = '0;
`endif

    assign bus.ALUOp_o    = ctrl_q.alu_op;
    assign bus.ALUSrc_o   = ctrl_q.alu_src;
    assign bus.RegWrite_o = ctrl_q.reg_write;
    assign bus.MemToReg_o = ctrl_q.mem_to_reg;
    assign bus.MemRead_o  = ctrl_q.mem_read;
    assign bus.MemWrite_o = ctrl_q.mem_write;
    assign bus.RS1data_o  = rs1_data_q;
    assign bus.RS2data_o  = rs2_data_q;
    assign bus.Imm_o      = imm_q;
    assign bus.funct_o    = funct_q;
    assign bus.RS1addr_o  = rs1_addr_q;
    assign bus.RS2addr_o  = rs2_addr_q;
    assign bus.RDaddr_o   = rd_addr_q;
    assign bus.hazard_o   = hazard_c;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then random traffic
// against an instruction-level model of the ID/EX boundary.
module tb_id_ex_stage;

    typedef struct packed {
        logic [1:0]  aluop;
        logic        alusrc;
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rda;
    } ex_t;

    localparam int K_R  = 0;
    localparam int K_LD = 1;
    localparam int K_ST = 2;

    logic clk;
    logic rst_n;
    ex_t  in_v;
    logic stall_v;
    logic flush_v;

    ex_t         exp_q;
    logic        pend_m;
    logic [31:0] cnt_m;
    logic        haz_seen;
    int          checks;
    int          failures;

    id_ex_stage_if #(.XLEN(32), .RAW(5)) bus ();

    id_ex_stage #(.XLEN(32), .RAW(5)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    assign bus.ALUOp_i    = in_v.aluop;
    assign bus.ALUSrc_i   = in_v.alusrc;
    assign bus.RegWrite_i = in_v.regwrite;
    assign bus.MemToReg_i = in_v.memtoreg;
    assign bus.MemRead_i  = in_v.memread;
    assign bus.MemWrite_i = in_v.memwrite;
    assign bus.RS1data_i  = in_v.rs1d;
    assign bus.RS2data_i  = in_v.rs2d;
    assign bus.Imm_i      = in_v.imm;
    assign bus.funct_i    = in_v.funct;
    assign bus.RS1addr_i  = in_v.rs1a;
    assign bus.RS2addr_i  = in_v.rs2a;
    assign bus.RDaddr_i   = in_v.rda;
    assign bus.stall_i    = stall_v;
    assign bus.flush_i    = flush_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ex_t mk(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2);
        ex_t t;
        t       = '0;
        t.rda   = rd;
        t.rs1a  = rs1;
        t.rs2a  = rs2;
        t.rs1d  = d1;
        t.rs2d  = d2;
        t.funct = 10'($urandom);
        case (kind)
            K_R:  begin t.aluop = 2'b00; t.regwrite = 1'b1; end
            K_LD: begin t.aluop = 2'b01; t.alusrc = 1'b1; t.regwrite = 1'b1;
                        t.memtoreg = 1'b1; t.memread = 1'b1; t.imm = 32'($urandom_range(0, 255)); end
            default: begin t.aluop = 2'b10; t.alusrc = 1'b1; t.memwrite = 1'b1;
                        t.imm = 32'($urandom_range(0, 255)); end
        endcase
        return t;
    endfunction

    function automatic ex_t observed();
        return {bus.ALUOp_o, bus.ALUSrc_o, bus.RegWrite_o, bus.MemToReg_o, bus.MemRead_o,
                bus.MemWrite_o, bus.RS1data_o, bus.RS2data_o, bus.Imm_o, bus.funct_o,
                bus.RS1addr_o, bus.RS2addr_o, bus.RDaddr_o};
    endfunction

    // Load in EX writing a real register that the instruction in ID reads
    function automatic logic model_hazard();
        return exp_q.memread && (exp_q.rda != 5'd0) &&
               ((exp_q.rda == in_v.rs1a) || (exp_q.rda == in_v.rs2a));
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef ID_EX_BUBBLE_CNT_EN
        return cnt_m;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ex"}, 128'(observed()), 128'(exp_q));
        chk({tag, "_cnt"}, 128'(bus.bubble_cnt_o), 128'(exp_cnt()));
    endtask

    task automatic model_reset();
        exp_q  = '0;
        pend_m = 1'b0;
        cnt_m  = 32'd0;
    endtask

    // One clock: check hazard before the edge, advance the model, check EX after it
    task automatic cycle(input string tag);
        logic haz;
        @(negedge clk);
        haz      = model_hazard();
        haz_seen = bus.hazard_o;
        chk({tag, "_haz"}, 128'(bus.hazard_o), 128'(haz));
        @(posedge clk);
        #1;
        if (stall_v) begin
            if (flush_v) pend_m = 1'b1;
        end else if (flush_v || pend_m || haz) begin
            exp_q  = '0;
            pend_m = 1'b0;
            cnt_m  = cnt_m + 32'd1;
        end else begin
            exp_q = in_v;
        end
        check_state(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        haz_seen = 1'b0;
        rst_n    = 1'b0;
        stall_v  = 1'b0;
        flush_v  = 1'b0;
        in_v     = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_haz", 128'(bus.hazard_o), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // add x3, x1, x2
        in_v = mk(K_R, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
        cycle("pass");
        chk("pass_regwrite", 128'(bus.RegWrite_o), 128'(1));
        chk("pass_aluop", 128'(bus.ALUOp_o), 128'(0));
        chk("pass_rs1d", 128'(bus.RS1data_o), 128'(5));
        chk("pass_rs2d", 128'(bus.RS2data_o), 128'(7));
        chk("pass_rd", 128'(bus.RDaddr_o), 128'(3));

        // lw x5 then add x6, x5, x1
        in_v = mk(K_LD, 5'd5, 5'd2, 5'd0, 32'd100, 32'd0);
        cycle("lu_load");
        in_v = mk(K_R, 5'd6, 5'd5, 5'd1, 32'd11, 32'd22);
        cycle("lu_bubble");
        chk("lu_haz_seen", 128'(haz_seen), 128'(1));
        chk("lu_bubble_rd", 128'(bus.RDaddr_o), 128'(0));
        chk("lu_bubble_ctl", 128'(bus.RegWrite_o), 128'(0));
        cycle("lu_add");
        chk("lu_add_rs1", 128'(bus.RS1addr_o), 128'(5));

        // lw x0 then add x6, x0, x1
        in_v = mk(K_LD, 5'd0, 5'd2, 5'd0, 32'd1, 32'd0);
        cycle("x0_load");
        in_v = mk(K_R, 5'd6, 5'd0, 5'd1, 32'd3, 32'd4);
        cycle("x0_add");
        chk("x0_haz_seen", 128'(haz_seen), 128'(0));
        chk("x0_add_rd", 128'(bus.RDaddr_o), 128'(6));

        // stall and flush together for two cycles
        in_v    = mk(K_R, 5'd9, 5'd7, 5'd8, 32'hA5A5A5A5, 32'h5A5A5A5A);
        stall_v = 1'b1;
        flush_v = 1'b1;
        cycle("sf_hold0");
        chk("sf_hold_rd", 128'(bus.RDaddr_o), 128'(6));
        cycle("sf_hold1");
        stall_v = 1'b0;
        flush_v = 1'b0;
        cycle("sf_bubble");
        chk("sf_bubble_ctl", 128'(bus.RegWrite_o), 128'(0));
        cycle("sf_load");
        chk("sf_load_rd", 128'(bus.RDaddr_o), 128'(9));

        // load-use held under stall, bubble only on the first free edge
        in_v = mk(K_LD, 5'd5, 5'd1, 5'd0, 32'd0, 32'd0);
        cycle("sh_load");
        in_v    = mk(K_R, 5'd6, 5'd5, 5'd2, 32'd1, 32'd2);
        stall_v = 1'b1;
        repeat (3) begin
            cycle("sh_stall");
            chk("sh_stall_haz", 128'(haz_seen), 128'(1));
            chk("sh_stall_memread", 128'(bus.MemRead_o), 128'(1));
        end
        stall_v = 1'b0;
        cycle("sh_bubble");
        chk("sh_bubble_rd", 128'(bus.RDaddr_o), 128'(0));
        cycle("sh_add");

        // mid-cycle reset with a load in EX and a pending flush
        in_v = mk(K_LD, 5'd7, 5'd1, 5'd0, 32'd0, 32'd0);
        cycle("mr_load");
        in_v    = mk(K_R, 5'd4, 5'd7, 5'd3, 32'd9, 32'd8);
        stall_v = 1'b1;
        flush_v = 1'b1;
        cycle("mr_pend");
        stall_v = 1'b0;
        flush_v = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("mr_reset");
        chk("mr_reset_haz", 128'(bus.hazard_o), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cycle("mr_after");
        chk("mr_after_rd", 128'(bus.RDaddr_o), 128'(4));

        // random traffic with a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            in_v      = ex_t'({$urandom, $urandom, $urandom, $urandom});
            in_v.rs1a = 5'($urandom_range(0, 7));
            in_v.rs2a = 5'($urandom_range(0, 7));
            in_v.rda  = 5'($urandom_range(0, 7));
            in_v.memread = ($urandom_range(0, 2) == 0);
            stall_v   = ($urandom_range(0, 4) == 0);
            flush_v   = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
